aes_key_schedule: RTL and testbench
===================================

# aes_key_schedule

Parametrised AES key schedule supporting AES-128, AES-192 and AES-256, selected at run time. It expands a cipher key one 32-bit word per cycle into an internal round-key store. The store is then read back as 128-bit round keys in forward (encrypt) or inverse (decrypt) round order. It sits beside the round datapath and replaces the single-round, 128-bit-only, byte-serial key expansion, with no expansion work needed per round.

## Interface
- MAX_KEY_BITS, 256, largest supported key size; legal values are 128, 192 and 256. It sizes key_in and the store depth: 4*(Nr_max+1) words, i.e. 44, 52 or 60.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; one clock, reset is synchronous and active-high.
- start  input  1  request expansion of key_in with mode key_len.
- key_len  input  2  0=128 (Nk=4, Nr=10), 1=192 (Nk=6, Nr=12), 2=256 (Nk=8, Nr=14), 3=illegal.
- key_in  input  MAX_KEY_BITS  cipher key, MSB-aligned; w[0] = key_in[MAX_KEY_BITS-1 -: 32].
- busy  output  1  high while expanding.
- done  output  1  one-cycle pulse when expansion completes.
- key_ready  output  1  store holds a valid schedule.
- cfg_err  output  1  one-cycle pulse when start is rejected.
- nr  output  4  Nr of the current schedule.
- rd_en  input  1  round-key read request.
- rd_round  input  4  round index r.
- rd_inv  input  1  1: return round key Nr-r (inverse order).
- rd_key  output  128  {w[4k], w[4k+1], w[4k+2], w[4k+3]}, with w[4k] in [127:96].
- rd_valid  output  1  rd_key valid; one-cycle pulse.
- rd_err  output  1  qualifies rd_valid; read was illegal.

## Operation
- States:
  - IDLE → EXPAND on an accepted start.
  - EXPAND → READY after the last word is written.
  - READY → EXPAND on an accepted start.
- Start acceptance:
  - start is accepted only in IDLE or READY.
  - start in EXPAND is ignored: no pulse, no effect.
  - start with key_len=3, or with a key longer than MAX_KEY_BITS, is rejected: cfg_err pulses and the state is unchanged (READY stays READY with its old schedule).
- On acceptance:
  - Write w[0..Nk-1] from key_in.
  - Latch Nk and Nr; set i=Nk and rcon=8'h01.
  - Clear key_ready and set busy.
- Each EXPAND cycle writes w[i] = w[i-Nk] ^ temp, then increments i. temp is selected as follows:
  - i mod Nk == 0: temp = SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}. rcon then becomes xtime(rcon): shift left 1, xor 8'h1B if bit 7 was set.
  - Nk == 8 and i mod 8 == 4: temp = SubWord(w[i-1]).
  - Otherwise: temp = w[i-1].
- Use four combinational S-box byte instances (SubWord). RotWord rotates bytes left by one: {b1, b2, b3, b0}.
- Expansion ends when i == 4*(Nr+1)-1 is written. Then busy clears, done pulses, key_ready sets and the state goes to READY.
- Reads:
  - Effective round k = rd_inv ? Nr-r : r.
  - A read is legal when key_ready=1 and r <= Nr.
  - An illegal read returns rd_key=0 with rd_err=1.
  - Reads are independent of expansion state; the store is never returned while key_ready=0.

## Timing
- Reset values:
  - State IDLE, i=0, rcon=8'h01.
  - busy, done, key_ready, cfg_err, rd_valid, rd_err are all 0.
  - nr=0 and rd_key=0.
  - Store contents are don't-care, because key_ready=0 blocks reads.
- Start is sampled at edge 0, and busy is high from edge 0.
- Expansion writes occur at edges 1..G, where G = 4(Nr+1)-Nk: 40 (AES-128), 46 (AES-192), 52 (AES-256).
- done and key_ready rise at edge G, and busy falls at edge G.
- A start at edge G+1 is accepted; back-to-back schedules have no dead cycle.
- Read latency is 1 cycle: rd_en at edge t gives rd_valid/rd_key/rd_err at edge t+1.
  - rd_key holds its value until the next read.
  - rd_valid and rd_err are pulses.
- A read in the same cycle as an accepted start sees the pre-start key_ready value, so a read of the old schedule completes.
- rst asserted mid-expansion returns to IDLE on that edge with key_ready=0. A start in the reset cycle is ignored.
- Combinational depth per cycle: one S-box plus two xor levels; no byte-serial sequencing.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
  - done exactly 40 cycles after start.
  - Read r=1 → a0fafe1788542cb123a339392a6c7605.
  - Read r=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192, key 000102…17 (MSB-aligned):
  - done after 46 cycles, nr=12.
  - Read r=0 with rd_inv=1 → a4970a331a78dc09c418c271e3a41d5d.
- AES-256, key 000102…1f:
  - done after 52 cycles.
  - Read r=14 → 24fc79ccbf0979e9371ac23c6d68de36.
  - Read r=0 with rd_inv=1 → same value.
  - Read r=15 → rd_err=1, rd_key=0.
- Control corner cases:
  - start with key_len=3 in READY → cfg_err pulse; old schedule still readable.
  - start during EXPAND → ignored; cycle count unchanged.
  - Read during EXPAND → rd_err=1.
- rst pulsed at cycle 20 of an AES-128 expansion:
  - key_ready=0 and busy=0 next cycle.
  - A fresh AES-128 start completes correctly in 40 cycles.
- Reference-model sweep: 200 random keys per mode against a software model, checking every round key in both rd_inv orders.

Source files
------------

// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key schedule: expands a cipher key one word per cycle into a
// round-key store, then serves 128-bit round keys in forward or inverse order.

module aes_key_schedule_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so invert the address before scaling.
  assign y = SBOX_TABLE[{~a, 3'b000} +: 8];
endmodule

module aes_key_schedule #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              key_len,
  input  logic [MAX_KEY_BITS-1:0] key_in,
  output logic                    busy,
  output logic                    done,
  output logic                    key_ready,
  output logic                    cfg_err,
  output logic [3:0]              nr,
  input  logic                    rd_en,
  input  logic [3:0]              rd_round,
  input  logic                    rd_inv,
  output logic [127:0]            rd_key,
  output logic                    rd_valid,
  output logic                    rd_err
);
  localparam int NK_MAX = MAX_KEY_BITS / 32;
  localparam int NR_MAX = NK_MAX + 6;
  localparam int DEPTH  = 4 * (NR_MAX + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_READY  = 2'd2;

  logic [1:0]  state;
  logic [5:0]  idx;
  logic [2:0]  pos;
  logic [7:0]  rcon;
  logic [3:0]  nk_q;
  logic [3:0]  nr_q;
  logic [31:0] store [DEPTH];

  logic [3:0]  nk_new;
  logic        cfg_ok;
  logic        accept;
  logic [31:0] prev_word;
  logic [31:0] back_word;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp;
  logic [31:0] new_word;
  logic [5:0]  last_idx;
  logic        pos_wrap;
  logic [7:0]  rcon_next;

  always_comb begin
    nk_new = 4'd4;
    case (key_len)
      2'd1:    nk_new = 4'd6;
      2'd2:    nk_new = 4'd8;
      default: nk_new = 4'd4;
    endcase
    cfg_ok = (key_len != 2'd3) && ((int'(nk_new) * 32) <= MAX_KEY_BITS);
  end

  assign accept = start && ((state == S_IDLE) || (state == S_READY)) && cfg_ok;

  // pos tracks i mod Nk so no divider is needed on the word index.
  assign prev_word = store[idx - 6'd1];
  assign back_word = store[idx - {2'b00, nk_q}];
  assign sub_in    = (pos == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  aes_key_schedule_sbox u_sbox0 (.a(sub_in[31:24]), .y(sub_out[31:24]));
  aes_key_schedule_sbox u_sbox1 (.a(sub_in[23:16]), .y(sub_out[23:16]));
  aes_key_schedule_sbox u_sbox2 (.a(sub_in[15:8]),  .y(sub_out[15:8]));
  aes_key_schedule_sbox u_sbox3 (.a(sub_in[7:0]),   .y(sub_out[7:0]));

  always_comb begin
    temp = prev_word;
    if (pos == 3'd0)
      temp = sub_out ^ {rcon, 24'h000000};
    else if ((nk_q == 4'd8) && (pos == 3'd4))
      temp = sub_out;
  end

  assign new_word  = back_word ^ temp;
  assign last_idx  = {nr_q + 4'd1, 2'b00} - 6'd1;
  assign pos_wrap  = ({1'b0, pos} == (nk_q - 4'd1));
  assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  // The store is not reset: key_ready gates every read of it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        for (int j = 0; j < NK_MAX; j++) begin
          if (j < int'(nk_new))
            store[6'(j)] <= key_in[MAX_KEY_BITS-1-32*j -: 32];
        end
      end else if (state == S_EXPAND) begin
        store[idx] <= new_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= 6'd0;
      pos       <= 3'd0;
      rcon      <= 8'h01;
      nk_q      <= 4'd0;
      nr_q      <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      key_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        S_EXPAND: begin
          idx <= idx + 6'd1;
          pos <= pos_wrap ? 3'd0 : pos + 3'd1;
          if (pos == 3'd0)
            rcon <= rcon_next;
          if (idx == last_idx) begin
            state     <= S_READY;
            busy      <= 1'b0;
            done      <= 1'b1;
            key_ready <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            if (cfg_ok) begin
              state     <= S_EXPAND;
              nk_q      <= nk_new;
              nr_q      <= nk_new + 4'd6;
              idx       <= {2'b00, nk_new};
              pos       <= 3'd0;
              rcon      <= 8'h01;
              key_ready <= 1'b0;
              busy      <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign nr = nr_q;

  logic [3:0] rd_k;
  logic [5:0] rd_base;
  logic       rd_legal;

  assign rd_k     = rd_inv ? (nr_q - rd_round) : rd_round;
  assign rd_base  = {rd_k, 2'b00};
  assign rd_legal = key_ready && (rd_round <= nr_q);

  // Uses registered key_ready, so a read beside an accepted start sees the old schedule.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key   <= 128'h0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en && !rd_legal;
      if (rd_en)
        rd_key <= rd_legal ? {store[rd_base], store[rd_base + 6'd1],
                              store[rd_base + 6'd2], store[rd_base + 6'd3]}
                           : 128'h0;
    end
  end
endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed vectors plus a reference-model sweep for aes_key_schedule.

module tb_aes_key_schedule;
  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam int TIMEOUT = 100;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy, done, key_ready, cfg_err;
  logic [3:0]   nr;
  logic         rd_en;
  logic [3:0]   rd_round;
  logic         rd_inv;
  logic [127:0] rd_key;
  logic         rd_valid, rd_err;

  int n_cmp  = 0;
  int n_fail = 0;

  aes_key_schedule #(.MAX_KEY_BITS(256)) dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .done(done), .key_ready(key_ready), .cfg_err(cfg_err), .nr(nr),
    .rd_en(rd_en), .rd_round(rd_round), .rd_inv(rd_inv),
    .rd_key(rd_key), .rd_valid(rd_valid), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   len;
    logic [255:0] key;
    logic [3:0]   round;
    logic         inv;
    logic [127:0] exp_key;
    logic         exp_err;
    int           exp_cycles;
    logic [3:0]   exp_nr;
  } vec_t;

  vec_t        vecs [8];
  logic [7:0]  sb [256];
  logic [31:0] mw [60];

  // Reference S-box built from the GF(2^8) inverse and affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic void build_sbox();
    logic [7:0] b;
    for (int a = 0; a < 256; a++) begin
      b = 8'h00;
      if (a != 0) begin
        b = 8'h01;
        for (int e = 0; e < 254; e++) b = gmul(b, 8'(a));
      end
      sb[a] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic void expand_model(input int nk, input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) mw[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = sub_word(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic kickStart(input logic [1:0] len, input logic [255:0] key);
    start = 1'b1; key_len = len; key_in = key;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < TIMEOUT) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("done_seen", 128'(done), 128'(1));
  endtask

  task automatic applyStimulus(input logic [1:0] len, input logic [255:0] key, output int cycles);
    kickStart(len, key);
    waitDone(cycles);
  endtask

  task automatic doRead(input logic [3:0] r, input logic inv);
    rd_en = 1'b1; rd_round = r; rd_inv = inv;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  int           cyc, wc, nk, k;
  logic [255:0] rk;

  initial begin
    rst = 1'b1; start = 1'b0; key_len = 2'd0; key_in = '0;
    rd_en = 1'b0; rd_round = 4'd0; rd_inv = 1'b0;
    build_sbox();

    vecs[0] = '{2'd0, K128, 4'd1,  1'b0, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0, 40, 4'd10};
    vecs[1] = '{2'd0, K128, 4'd10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, 40, 4'd10};
    vecs[2] = '{2'd0, K128, 4'd0,  1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, 40, 4'd10};
    vecs[3] = '{2'd0, K128, 4'd0,  1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 40, 4'd10};
    vecs[4] = '{2'd1, K192, 4'd0,  1'b1, 128'ha4970a331a78dc09c418c271e3a41d5d, 1'b0, 46, 4'd12};
    vecs[5] = '{2'd2, K256, 4'd0,  1'b0, 128'h000102030405060708090a0b0c0d0e0f, 1'b0, 52, 4'd14};
    vecs[6] = '{2'd2, K256, 4'd15, 1'b0, 128'h0,                                1'b1, 52, 4'd14};
    vecs[7] = '{2'd2, K256, 4'd14, 1'b0, 128'h24fc79ccbf0979e9371ac23c6d68de36, 1'b0, 52, 4'd14};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_flags", 128'({busy, done, key_ready, cfg_err, rd_valid, rd_err, nr}), 128'h0);
    checkOutput("reset_rd_key", rd_key, 128'h0);
    rst = 1'b0;

    doRead(4'd0, 1'b0);
    checkOutput("idle_read_flags", 128'({rd_valid, rd_err}), 128'(2'b11));
    checkOutput("idle_read_key", rd_key, 128'h0);

    $display("[TB] directed vectors");
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].len, vecs[v].key, cyc);
      checkOutput("vec_cycles", 128'(cyc), 128'(vecs[v].exp_cycles));
      checkOutput("vec_nr", 128'(nr), 128'(vecs[v].exp_nr));
      checkOutput("vec_ready", 128'({busy, key_ready}), 128'(2'b01));
      doRead(vecs[v].round, vecs[v].inv);
      checkOutput("vec_done_pulse", 128'(done), 128'h0);
      checkOutput("vec_rd_key", rd_key, vecs[v].exp_key);
      checkOutput("vec_rd_flags", 128'({rd_valid, rd_err}), 128'({1'b1, vecs[v].exp_err}));
    end

    $display("[TB] illegal key_len in READY");
    kickStart(2'd3, K128);
    checkOutput("cfg_err_pulse", 128'({cfg_err, busy, key_ready}), 128'(3'b101));
    @(posedge clk); #1;
    checkOutput("cfg_err_clear", 128'(cfg_err), 128'h0);
    doRead(4'd14, 1'b0);
    checkOutput("cfg_err_old_key", rd_key, 128'h24fc79ccbf0979e9371ac23c6d68de36);

    $display("[TB] read alongside accepted start");
    start = 1'b1; key_len = 2'd0; key_in = K128;
    rd_en = 1'b1; rd_round = 4'd14; rd_inv = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; rd_en = 1'b0;
    checkOutput("same_cycle_rd_key", rd_key, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    checkOutput("same_cycle_flags", 128'({rd_valid, rd_err, busy, key_ready}), 128'(4'b1010));
    waitDone(wc);
    checkOutput("same_cycle_cycles", 128'(wc), 128'(40));
    doRead(4'd1, 1'b0);
    checkOutput("same_cycle_new_key", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);

    $display("[TB] read and start during EXPAND");
    kickStart(2'd2, K256);
    doRead(4'd0, 1'b0);
    checkOutput("expand_read_flags", 128'({rd_valid, rd_err}), 128'(2'b11));
    checkOutput("expand_read_key", rd_key, 128'h0);
    kickStart(2'd0, K128);
    checkOutput("expand_start_ignored", 128'({busy, cfg_err, nr}), 128'({1'b1, 1'b0, 4'd14}));
    waitDone(wc);
    checkOutput("expand_start_cycles", 128'(wc + 2), 128'(52));
    doRead(4'd14, 1'b0);
    checkOutput("expand_start_key", rd_key, 128'h24fc79ccbf0979e9371ac23c6d68de36);

    $display("[TB] reset mid-expansion");
    kickStart(2'd0, K128);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1; key_len = 2'd0; key_in = K128;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    checkOutput("mid_rst_flags", 128'({busy, key_ready, done, nr}), 128'h0);
    @(posedge clk); #1;
    checkOutput("mid_rst_start_ignored", 128'(busy), 128'h0);
    applyStimulus(2'd0, K128, cyc);
    checkOutput("mid_rst_cycles", 128'(cyc), 128'(40));
    doRead(4'd10, 1'b0);
    checkOutput("mid_rst_key", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(posedge clk); #1;
    checkOutput("rd_key_hold", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    checkOutput("rd_valid_pulse", 128'({rd_valid, rd_err}), 128'h0);

    $display("[TB] reference-model sweep");
    for (int m = 0; m < 3; m++) begin
      nk = 4 + 2 * m;
      for (int n = 0; n < 200; n++) begin
        rk = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
        expand_model(nk, rk);
        applyStimulus(2'(m), rk, cyc);
        checkOutput("sweep_cycles", 128'(cyc), 128'(4 * (nk + 7) - nk));
        for (int inv = 0; inv < 2; inv++) begin
          for (int r = 0; r <= nk + 6; r++) begin
            k = (inv != 0) ? (nk + 6 - r) : r;
            doRead(4'(r), 1'(inv));
            checkOutput("sweep_key", rd_key, {mw[4*k], mw[4*k+1], mw[4*k+2], mw[4*k+3]});
            checkOutput("sweep_flags", 128'({rd_valid, rd_err}), 128'(2'b10));
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
